// File: rtl/avalon_mem_responder_pkg.sv
// Shared definitions for the Avalon memory responder.
//   state_t     : responder FSM states (IDLE, COUNT, DONE, CLEAR)
//   BYTE_LANES  : byte lanes per 32-bit word
//   WORD_W      : data word width
//   word_index  : byte address -> word index (drops the two byte-offset bits)
package avalon_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2,
      CLEAR = 2'd3
   } state_t;

   localparam int BYTE_LANES = 4;
   localparam int WORD_W     = 32;

   // Full-width word index; callers keep only the low ADDR_W bits, which is
   // what makes addresses alias across the upper address bits.
   function automatic logic [31:0] word_index(input logic [31:0] addr);
      return {2'b00, addr[31:2]};
   endfunction

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM bus bundle between a CPU master and the memory responder.
//   address/read/write/byteenable/writedata : master -> slave
//   waitrequest/readdata                    : slave -> master
interface avalon_mem_responder_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata
   );
endinterface

// File: rtl/avalon_mem_responder_array.sv
// avalon_mem_array: 2^ADDR_W x 32 word memory.
//   bus_*   : byte-enabled bus write source (lanes gated by bus_be)
//   clear_* : full-word zero write source used by the clear sequence
//   load_*  : full-word preload source, highest priority on the same word
//   rd_idx / rd_data : asynchronous read port (registered by the caller)
// The memory has no reset so contents survive a reset of the responder.
module avalon_mem_array
   import avalon_mem_responder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  bus_we,
   input  logic [ADDR_W-1:0]     bus_idx,
   input  logic [BYTE_LANES-1:0] bus_be,
   input  logic [WORD_W-1:0]     bus_wdata,
   input  logic                  clear_we,
   input  logic [ADDR_W-1:0]     clear_idx,
   input  logic                  load_we,
   input  logic [ADDR_W-1:0]     load_idx,
   input  logic [WORD_W-1:0]     load_data,
   input  logic [ADDR_W-1:0]     rd_idx,
   output logic [WORD_W-1:0]     rd_data
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0]     mem_r [DEPTH];
   logic                  wr_en_s;
   logic [ADDR_W-1:0]     wr_idx_s;
   logic [BYTE_LANES-1:0] wr_be_s;
   logic [WORD_W-1:0]     wr_data_s;

   // Select the byte-enabled port source; bus and clear are never active together
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = bus_idx;
      wr_be_s   = bus_be;
      wr_data_s = bus_wdata;
      if (bus_we) begin
         wr_en_s = 1'b1;
      end else if (clear_we) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = clear_idx;
         wr_be_s   = {BYTE_LANES{1'b1}};
         wr_data_s = {WORD_W{1'b0}};
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Memory update; the preload is assigned last so it wins on a shared word
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int b = 0; b < BYTE_LANES; b++) begin
            if (wr_be_s[b]) begin
               mem_r[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
            end
         end
      end
      if (load_we) begin
         mem_r[load_idx] <= load_data;
      end
   end

   assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave answering a CPU master from on-chip word memory.
//   clk, reset (async, active low)
//   bus        : Avalon slave modport (address/read/write/byteenable/
//                writedata in, waitrequest/readdata out)
//   load_en/load_addr/load_data : full-word preload, usable in any state
//   mem_clear  : pulse starting a zero-fill of every word (IDLE only)
//   clear_busy : high while the zero-fill runs
//   err        : sticky protocol error, cleared only by reset
// Each transfer spends WAIT_CYCLES states in COUNT before one DONE cycle.
module avalon_mem_responder
   import avalon_mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   avalon_mem_responder_if.slave bus,
   input  logic                  load_en,
   input  logic [31:0]           load_addr,
   input  logic [31:0]           load_data,
   input  logic                  mem_clear,
   output logic                  clear_busy,
   output logic                  err
);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 1) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};
   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

   state_t                state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [ADDR_W-1:0]     idx_r;
   logic [ADDR_W-1:0]     clear_idx_r;
   logic                  is_write_r;
   logic                  drop_r;
   logic [BYTE_LANES-1:0] be_r;
   logic [WORD_W-1:0]     wdata_r;
   logic [WORD_W-1:0]     readdata_r;
   logic                  clear_busy_r;
   logic                  err_r;

   logic [31:0]           bus_word_s;
   logic [31:0]           load_word_s;
   logic [ADDR_W-1:0]     bus_idx_s;
   logic [ADDR_W-1:0]     load_idx_s;
   logic [ADDR_W-1:0]     rd_idx_s;
   logic [WORD_W-1:0]     rd_word_s;
   logic                  one_req_s;
   logic                  both_req_s;
   logic                  cmd_held_s;
   logic                  bus_we_s;
   logic                  clear_we_s;
   logic                  waitrequest_s;
   logic                  unused_bits_s;

   assign bus_word_s    = word_index(bus.address);
   assign load_word_s   = word_index(load_addr);
   assign bus_idx_s     = bus_word_s[ADDR_W-1:0];
   assign load_idx_s    = load_word_s[ADDR_W-1:0];
   assign unused_bits_s = ^{bus_word_s[31:ADDR_W], load_word_s[31:ADDR_W]};

   assign one_req_s  = bus.read ^ bus.write;
   assign both_req_s = bus.read & bus.write;
   assign cmd_held_s = is_write_r ? bus.write : bus.read;

   // A write commits on the DONE edge unless the master abandoned it in COUNT
   assign bus_we_s   = (state_r == DONE) && is_write_r && !drop_r;
   assign clear_we_s = (state_r == CLEAR);

   // Read address: live bus index on the zero-wait IDLE->DONE path, captured index otherwise
   always_comb begin
      rd_idx_s = idx_r;
      if (state_r == IDLE) begin
         rd_idx_s = bus_idx_s;
      end else begin
         rd_idx_s = idx_r;
      end
   end

   // Wait-request decode; in IDLE it mirrors a lone command so idle cycles stay ready
   always_comb begin
      waitrequest_s = 1'b1;
      case (state_r)
         IDLE:    waitrequest_s = one_req_s;
         COUNT:   waitrequest_s = 1'b1;
         DONE:    waitrequest_s = 1'b0;
         CLEAR:   waitrequest_s = 1'b1;
         default: waitrequest_s = 1'b1;
      endcase
   end

   // Responder FSM with wait counter, clear sequencer, read data and error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         idx_r        <= {ADDR_W{1'b0}};
         clear_idx_r  <= {ADDR_W{1'b0}};
         is_write_r   <= 1'b0;
         drop_r       <= 1'b0;
         be_r         <= {BYTE_LANES{1'b0}};
         wdata_r      <= {WORD_W{1'b0}};
         readdata_r   <= {WORD_W{1'b0}};
         clear_busy_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         if (mem_clear && (state_r != IDLE)) begin
            err_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               drop_r <= 1'b0;
               if (mem_clear) begin
                  state_r      <= CLEAR;
                  clear_idx_r  <= {ADDR_W{1'b0}};
                  clear_busy_r <= 1'b1;
               end else if (both_req_s) begin
                  err_r <= 1'b1;
               end else if (one_req_s) begin
                  idx_r      <= bus_idx_s;
                  is_write_r <= bus.write;
                  be_r       <= bus.byteenable;
                  wdata_r    <= bus.writedata;
                  if (WAIT_CYCLES == 0) begin
                     state_r <= DONE;
                     if (!bus.write) begin
                        readdata_r <= rd_word_s;
                     end
                  end else begin
                     state_r <= COUNT;
                     cnt_r   <= CNT_INIT;
                  end
               end
            end
            COUNT: begin
               if (!cmd_held_s) begin
                  drop_r <= 1'b1;
                  err_r  <= 1'b1;
               end
               if (cnt_r == {CNT_W{1'b0}}) begin
                  state_r <= DONE;
                  if (!is_write_r) begin
                     readdata_r <= rd_word_s;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            CLEAR: begin
               if (clear_idx_r == LAST_IDX) begin
                  state_r      <= IDLE;
                  clear_busy_r <= 1'b0;
               end else begin
                  clear_idx_r <= clear_idx_r + ADDR_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   avalon_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk       (clk),
      .bus_we    (bus_we_s),
      .bus_idx   (idx_r),
      .bus_be    (be_r),
      .bus_wdata (wdata_r),
      .clear_we  (clear_we_s),
      .clear_idx (clear_idx_r),
      .load_we   (load_en),
      .load_idx  (load_idx_s),
      .load_data (load_data),
      .rd_idx    (rd_idx_s),
      .rd_data   (rd_word_s)
   );

   assign bus.waitrequest = waitrequest_s;
   assign bus.readdata    = readdata_r;
   assign clear_busy      = clear_busy_r;
   assign err             = err_r;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed plus randomized bench for avalon_mem_responder (ADDR_W=4,
// WAIT_CYCLES=2) checked against a word-array model of the memory.
module tb_avalon_mem_responder;
   localparam int AW    = 4;
   localparam int WAITS = 2;
   localparam int DEPTH = 16;

   logic        clk;
   logic        reset;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        mem_clear;
   logic        clear_busy;
   logic        err;

   int n_cmp;
   int n_err;

   logic [31:0] mem_m [DEPTH];

   avalon_mem_responder_if bus ();

   avalon_mem_responder #(
      .ADDR_W      (AW),
      .WAIT_CYCLES (WAITS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .mem_clear  (mem_clear),
      .clear_busy (clear_busy),
      .err        (err)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_idx(input logic [31:0] addr);
      return int'((addr / 32'd4) % 32'd16);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      load_en = 1'b1; load_addr = addr; load_data = data;
      @(posedge clk); #1;
      load_en = 1'b0;
      mem_m[m_idx(addr)] = data;
   endtask

   // One full transfer; exp_hi is the number of cycles waitrequest must stay high
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data, input int exp_hi, input string tag);
      int hi;
      @(negedge clk);
      bus.address = addr; bus.read = !wr; bus.write = wr;
      bus.byteenable = be; bus.writedata = data;
      hi = 0;
      for (int k = 0; k < 200; k++) begin
         #1;
         if (bus.waitrequest !== 1'b1) break;
         hi++;
         @(negedge clk);
      end
      check({tag, "_wait"}, 32'(hi), 32'(exp_hi));
      if (!wr) check({tag, "_rdata"}, bus.readdata, mem_m[m_idx(addr)]);
      @(posedge clk); #1;
      bus.read = 1'b0; bus.write = 1'b0;
      if (wr) mem_m[m_idx(addr)] = merge(mem_m[m_idx(addr)], data, be);
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
   endtask

   initial begin
      int cnt;
      logic [31:0] a, d;
      logic [3:0]  be;
      n_cmp = 0; n_err = 0;
      reset = 1'b0; load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0; mem_clear = 1'b0;
      bus.address = 32'd0; bus.read = 1'b0; bus.write = 1'b0;
      bus.byteenable = 4'h0; bus.writedata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      #1;
      check("rst_wait", {31'd0, bus.waitrequest}, 32'd0);
      check("rst_rdata", bus.readdata, 32'd0);
      check("rst_busy", {31'd0, clear_busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);

      // Clear everything: busy for exactly DEPTH cycles
      @(negedge clk); mem_clear = 1'b1;
      @(posedge clk); #1; mem_clear = 1'b0;
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!clear_busy) break;
         cnt++;
      end
      check("clear_len", 32'(cnt), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
      xfer(1'b0, 32'h0000_0000, 4'h0, 32'd0, WAITS + 1, "clr_rd0");
      xfer(1'b0, 32'h0000_003C, 4'h0, 32'd0, WAITS + 1, "clr_rd3c");
      check("clr_err", {31'd0, err}, 32'd0);

      // Preloaded word read back with the configured latency
      preload(32'h04, 32'h2402A234);
      xfer(1'b0, 32'h04, 4'h0, 32'd0, WAITS + 1, "pre_rd");
      check("pre_const", mem_m[1], 32'h2402A234);

      // Byte-lane merge
      preload(32'h08, 32'h11223344);
      xfer(1'b1, 32'h08, 4'b0101, 32'hDEADBEEF, WAITS + 1, "be_wr");
      @(negedge clk);
      xfer(1'b0, 32'h08, 4'h0, 32'd0, WAITS + 1, "be_rd");
      check("be_model", mem_m[2], 32'h11AD33EF);

      // Back-to-back write then read of the same aliased word
      xfer(1'b1, 32'h0000_0024, 4'hF, 32'hCAFE0001, WAITS + 1, "b2b_wr");
      xfer(1'b0, 32'hFF00_0027, 4'h0, 32'd0, WAITS + 1, "b2b_rd");

      // read and write together: ready at once, error set
      @(negedge clk); bus.read = 1'b1; bus.write = 1'b1; bus.address = 32'h0C;
      #1; check("both_wait", {31'd0, bus.waitrequest}, 32'd0);
      @(posedge clk); #1; bus.read = 1'b0; bus.write = 1'b0;
      check("both_err", {31'd0, err}, 32'd1);
      xfer(1'b0, 32'h0C, 4'h0, 32'd0, WAITS + 1, "both_next");
      check("both_err_hold", {31'd0, err}, 32'd1);

      // Preload on the DONE-entry edge: read returns the old word
      @(negedge clk); bus.read = 1'b1; bus.address = 32'h04;
      @(negedge clk);
      @(negedge clk); load_en = 1'b1; load_addr = 32'h04; load_data = 32'h5A5A_0F0F;
      @(posedge clk); #1; load_en = 1'b0;
      @(negedge clk);
      check("race_wait", {31'd0, bus.waitrequest}, 32'd0);
      check("race_old", bus.readdata, 32'h2402A234);
      @(posedge clk); #1; bus.read = 1'b0;
      mem_m[1] = 32'h5A5A_0F0F;
      xfer(1'b0, 32'h04, 4'h0, 32'd0, WAITS + 1, "race_new");

      // Read issued during a clear finishes after the clear
      @(negedge clk); mem_clear = 1'b1;
      @(posedge clk); #1; mem_clear = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
      xfer(1'b0, 32'h3C, 4'h0, 32'd0, DEPTH + WAITS + 1, "clr_rd_during");
      xfer(1'b0, 32'h04, 4'h0, 32'd0, WAITS + 1, "clr_rd_after");

      // Reset in COUNT of a write: aborted, memory untouched
      preload(32'h10, 32'h0BAD_F00D);
      xfer(1'b0, 32'h10, 4'h0, 32'd0, WAITS + 1, "rst_pre_rd");
      @(negedge clk); bus.write = 1'b1; bus.address = 32'h10;
      bus.byteenable = 4'hF; bus.writedata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      #1;
      check("mid_rst_rdata", bus.readdata, 32'd0);
      check("mid_rst_err", {31'd0, err}, 32'd0);
      check("mid_rst_wait", {31'd0, bus.waitrequest}, 32'd1);
      bus.write = 1'b0;
      #1; check("mid_rst_idle", {31'd0, bus.waitrequest}, 32'd0);
      @(negedge clk); reset = 1'b1;
      xfer(1'b0, 32'h10, 4'h0, 32'd0, WAITS + 1, "mid_rst_mem");

      // mem_clear outside IDLE: ignored, error set, transfer unaffected
      @(negedge clk); bus.read = 1'b1; bus.address = 32'h10;
      @(negedge clk); mem_clear = 1'b1;
      @(posedge clk); #1; mem_clear = 1'b0;
      check("busy_clr_err", {31'd0, err}, 32'd1);
      check("busy_clr_nobusy", {31'd0, clear_busy}, 32'd0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.waitrequest !== 1'b1) break;
      end
      check("busy_clr_rdata", bus.readdata, 32'h0BAD_F00D);
      @(posedge clk); #1; bus.read = 1'b0;

      // Write dropped in COUNT: not committed, error set
      pulse_reset();
      #1; check("drop_err0", {31'd0, err}, 32'd0);
      preload(32'h14, 32'h7777_8888);
      @(negedge clk); bus.write = 1'b1; bus.address = 32'h14;
      bus.byteenable = 4'hF; bus.writedata = 32'h0000_1111;
      @(posedge clk); #1; bus.write = 1'b0;
      repeat (WAITS + 2) @(posedge clk);
      #1;
      check("drop_err", {31'd0, err}, 32'd1);
      xfer(1'b0, 32'h14, 4'h0, 32'd0, WAITS + 1, "drop_mem");

      // Randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         a  = $urandom();
         d  = $urandom();
         be = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0: preload(a, d);
            1: xfer(1'b1, a, be, d, WAITS + 1, "rnd_wr");
            default: xfer(1'b0, a, 4'h0, 32'd0, WAITS + 1, "rnd_rd");
         endcase
      end
      for (int i = 0; i < DEPTH; i++) begin
         xfer(1'b0, 32'(i * 4), 4'h0, 32'd0, WAITS + 1, "final_rd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
